// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator for RV32I loads/stores over a word-only memory port,
// with read-modify-write for byte and half stores.
module load_store_unit #(
    parameter int MEM_BYTES  = 20,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic [31:0] address,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] readData
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
    localparam int CW = $clog2(RD_LATENCY + 1);

    state_t        state_q, state_d;
    logic          store_q, store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wr_word_q, wr_word_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_fault_q, rsp_fault_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        bad_f3, misaligned, out_of_range, req_fault;
    logic [4:0]  sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val, mask, merged;

    assign bad_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                    (req_store && req_funct3[2]);
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign out_of_range = ({1'b0, req_addr[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES);
    assign req_fault = bad_f3 || misaligned || out_of_range;

    // half accesses are 2-aligned, so the byte shift also selects the half lane
    assign sh     = {addr_q[1:0], 3'b000};
    assign lane_b = 8'(readData >> sh);
    assign lane_h = 16'(readData >> sh);
    assign ld_val = funct3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                    funct3_q == 3'b100 ? {24'b0, lane_b} :
                    funct3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                    funct3_q == 3'b101 ? {16'b0, lane_h} : readData;
    assign mask   = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    assign merged = (readData & ~(mask << sh)) | ((wr_word_q & mask) << sh);

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wr_word_d   = wr_word_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                store_d     = req_store;
                funct3_d    = req_funct3;
                addr_d      = req_addr;
                wr_word_d   = req_wdata;
                rsp_data_d  = '0;
                rsp_fault_d = req_fault;
                cnt_d       = '0;
                state_d     = req_fault ? RSP : (req_store && req_funct3 == 3'b010) ? WR : RD;
            end
            RD: if (cnt_q == CW'(RD_LATENCY - 1)) begin
                wr_word_d  = store_q ? merged : wr_word_q;
                rsp_data_d = store_q ? '0 : ld_val;
                state_d    = store_q ? WR : RSP;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WR:      state_d = RSP;
            RSP:     state_d = rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wr_word_q   <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wr_word_q   <= wr_word_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready    = state_q == IDLE;
    assign rsp_valid    = state_q == RSP;
    assign memRead      = state_q == RD;
    assign memWrite     = state_q == WR;
    assign address      = (memRead || memWrite) ? {addr_q[31:2], 2'b00} : '0;
    assign memWriteData = memWrite ? wr_word_q : '0;
    assign rsp_data     = rsp_data_q;
    assign rsp_fault    = rsp_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random loads/stores against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_store = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_fault, memWrite, memRead;
    logic [31:0] rsp_data, address, memWriteData, readData;

    logic [31:0] tbmem [5];
    logic [7:0]  rm [20];
    int checks = 0, errors = 0, both_hi = 0, addr_bad = 0;

    load_store_unit #(.MEM_BYTES(20), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fault(rsp_fault), .address(address),
        .memWriteData(memWriteData), .memWrite(memWrite), .memRead(memRead),
        .readData(readData)
    );

    always #5 clk = ~clk;

    assign readData = (memRead && address < 32'd20) ? tbmem[int'(address[4:2])] : 32'h0;
    always @(posedge clk) if (memWrite && address < 32'd20) tbmem[int'(address[4:2])] <= memWriteData;
    always @(negedge clk) begin
        if (memRead && memWrite) both_hi++;
        if (!memRead && !memWrite && address != 0) addr_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, want);
        end
    endtask

    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
        int size, lat, rdc, wrc, wa, val;
        bit flt, exp_rd;
        logic [31:0] want_d, want_wd, seen_wd, seen_addr, held;
        size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
        flt = size == 0 || (st && f3 >= 4) || (int'(a[1:0]) % size != 0) ||
              (longint'({32'b0, a[31:2], 2'b00}) + 3 >= 20);
        exp_rd = !flt && !(st && size == 4);
        want_d = 0;
        want_wd = 0;
        wa = flt ? 0 : int'({a[31:2], 2'b00});
        if (!flt && !st) begin
            val = 0;
            for (int i = size - 1; i >= 0; i--) val = val * 256 + int'(rm[int'(a) + i]);
            if (f3 < 4 && size < 4 && val >= (1 << (8 * size - 1))) val -= (1 << (8 * size));
            want_d = 32'(val);
        end
        if (!flt && st) begin
            for (int i = 0; i < size; i++) rm[int'(a) + i] = wd[8*i +: 8];
            want_wd = {rm[wa + 3], rm[wa + 2], rm[wa + 1], rm[wa]};
        end
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1;
        req_valid = 0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; rdc = 0; wrc = 0; seen_wd = 0; seen_addr = 0;
        while (lat <= 20) begin
            @(negedge clk);
            lat++;
            if (memRead) begin rdc++; seen_addr = address; end
            if (memWrite) begin wrc++; seen_addr = address; seen_wd = memWriteData; end
            if (rsp_valid) break;
        end
        chk("latency", 32'(lat), flt ? 1 : (st && size < 4) ? 3 : 2);
        chk("rd_cycles", 32'(rdc), exp_rd ? 1 : 0);
        chk("wr_cycles", 32'(wrc), (!flt && st) ? 1 : 0);
        chk("rsp_fault", 32'(rsp_fault), 32'(flt));
        chk("rsp_data", rsp_data, want_d);
        chk("req_ready_busy", 32'(req_ready), 0);
        if (!flt && st) chk("mem_wdata", seen_wd, want_wd);
        if (!flt) chk("mem_addr", seen_addr, 32'(wa));
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", rsp_data, held);
            chk("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("post_valid", 32'(rsp_valid), 0);
        chk("post_ready", 32'(req_ready), 1);
    endtask

    initial begin
        tbmem[0] = 32'h9; tbmem[1] = 32'h6;
        for (int i = 2; i < 5; i++) tbmem[i] = 32'h0101_0101;
        for (int i = 0; i < 20; i++) rm[i] = tbmem[i / 4][8 * (i % 4) +: 8];
        #12;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_fault", 32'(rsp_fault), 0);
        chk("rst_address", address, 0);
        chk("rst_wdata", memWriteData, 0);
        chk("rst_strobes", {memRead, memWrite}, 0);
        @(negedge clk);
        reset = 1;
        run(0, 3'b010, 0, 0, 0);
        run(1, 3'b000, 4, 32'hFF, 0);
        run(0, 3'b000, 4, 0, 0);
        run(0, 3'b100, 4, 0, 0);
        run(1, 3'b001, 10, 32'h8001, 0);
        run(0, 3'b001, 10, 0, 0);
        run(0, 3'b101, 10, 0, 0);
        run(0, 3'b010, 2, 0, 0);
        run(1, 3'b001, 9, 32'h1234, 0);
        run(1, 3'b010, 20, 32'h5555, 0);
        run(0, 3'b011, 0, 0, 0);
        run(1, 3'b100, 0, 0, 0);
        run(0, 3'b010, 16, 0, 0);
        run(0, 3'b010, 32'hFFFF_FFFC, 0, 0);
        run(0, 3'b010, 0, 0, 3);
        @(negedge clk);
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 4;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        chk("mid_rd", 32'(memRead), 1);
        #2 reset = 0;
        #1;
        chk("abort_read", 32'(memRead), 0);
        chk("abort_write", 32'(memWrite), 0);
        chk("abort_addr", address, 0);
        chk("abort_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 1);
        chk("rel_valid", 32'(rsp_valid), 0);
        for (int n = 0; n < 80; n++)
            run(1'($urandom), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 23)),
                $urandom, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
        run(0, 3'b010, 8, 0, 0);
        chk("excl_strobes", 32'(both_hi), 0);
        chk("idle_addr_zero", 32'(addr_bad), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
